sha1_core_iter: RTL and testbench

- Iterative SHA-1 compression core. Consumes one pre-padded 512-bit block per transaction and produces the 160-bit chaining digest.
- Supports multi-block messages via a first/continue flag; chaining state is held internally.
- Rounds-per-cycle is parametrised to trade area against latency.
- Sits between the padding/block-assembly front end and the digest consumer.

---
 rtl/sha1_pkg.sv | 73 +++++++
 rtl/sha1_round.sv | 26 ++
 rtl/sha1_core_iter.sv | 144 ++++++++++++++
 tb/tb_sha1_core_iter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, state typedef and round/schedule helper functions.
// Pure combinational helpers: no latency, no flow control.
package sha1_pkg;

    localparam logic [31:0] H0 = 32'h67452301;
    localparam logic [31:0] H1 = 32'hEFCDAB89;
    localparam logic [31:0] H2 = 32'h98BADCFE;
    localparam logic [31:0] H3 = 32'h10325476;
    localparam logic [31:0] H4 = 32'hC3D2E1F0;

    localparam logic [31:0] K0 = 32'h5A827999;
    localparam logic [31:0] K1 = 32'h6ED9EBA1;
    localparam logic [31:0] K2 = 32'h8F1BBCDC;
    localparam logic [31:0] K3 = 32'hCA62C1D6;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
    } sha1_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN,
        S_DONE
    } sha1_fsm_t;

    localparam sha1_state_t H_INIT = '{a: H0, b: H1, c: H2, d: H3, e: H4};

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] f_ch(input logic [31:0] b, input logic [31:0] c,
                                         input logic [31:0] d);
        return (b & c) | (~b & d);
    endfunction

    function automatic logic [31:0] f_parity(input logic [31:0] b, input logic [31:0] c,
                                             input logic [31:0] d);
        return b ^ c ^ d;
    endfunction

    function automatic logic [31:0] f_maj(input logic [31:0] b, input logic [31:0] c,
                                          input logic [31:0] d);
        return (b & c) | (b & d) | (c & d);
    endfunction

    function automatic logic [31:0] k_of(input logic [6:0] t);
        if (t < 7'd20)      return K0;
        else if (t < 7'd40) return K1;
        else if (t < 7'd60) return K2;
        else                return K3;
    endfunction

    function automatic logic [31:0] f_of(input logic [6:0] t, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
        if (t < 7'd20)      return f_ch(b, c, d);
        else if (t < 7'd40) return f_parity(b, c, d);
        else if (t < 7'd60) return f_maj(b, c, d);
        else                return f_parity(b, c, d);
    endfunction

    // W[t] from W[t-3], W[t-8], W[t-14], W[t-16]
    function automatic logic [31:0] sched_word(input logic [31:0] w3, input logic [31:0] w8,
                                               input logic [31:0] w14, input logic [31:0] w16);
        return rotl(w3 ^ w8 ^ w14 ^ w16, 1);
    endfunction

endpackage

// File: rtl/sha1_round.sv
// One combinational SHA-1 round; f and K are picked from this round's own t.
// Zero latency, no flow control.
module sha1_round
    import sha1_pkg::*;
(
    input  logic [6:0]  t,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  logic [31:0] e,
    input  logic [31:0] w,
    output logic [31:0] a_nxt,
    output logic [31:0] b_nxt,
    output logic [31:0] c_nxt,
    output logic [31:0] d_nxt,
    output logic [31:0] e_nxt
);

    assign a_nxt = rotl(a, 5) + f_of(t, b, c, d) + e + k_of(t) + w;
    assign b_nxt = a;
    assign c_nxt = rotl(b, 30);
    assign d_nxt = c;
    assign e_nxt = d;

endmodule

// File: rtl/sha1_core_iter.sv
// Iterative SHA-1 compression, ROUNDS_PER_CYCLE rounds/clock; digest valid 80/R+1 edges after accept.
// Accepts only in IDLE; digest is held in DONE until out_ready, blocking new input meanwhile.
module sha1_core_iter
    import sha1_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_first,
    input  logic [511:0] d_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [159:0] d_out,
    output logic         busy
);

    localparam int R    = ROUNDS_PER_CYCLE;
    localparam int NCYC = 80 / ROUNDS_PER_CYCLE;

    if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_rpc
        $error("sha1_core_iter: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    sha1_fsm_t   state, state_nxt;
    logic [6:0]  t;
    sha1_state_t vars, base, chain, vars_nxt, digest;
    logic [31:0] win       [16];
    logic [31:0] win_shift [16];
    logic [31:0] nw        [R];
    logic        last_run;

    assign last_run = (t == 7'(R * (NCYC - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = S_RUN;
            end
            S_RUN:   if (last_run) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // New words W[t+16+j]; lane 3 needs W[t+16], which is recomputed locally.
    for (genvar j = 0; j < R; j++) begin : g_sched
        logic [31:0] w13;
        if (j == 3) begin : g_fold
            assign w13 = sched_word(win[13], win[8], win[2], win[0]);
        end else begin : g_direct
            assign w13 = win[13 + j];
        end
        assign nw[j] = sched_word(w13, win[8 + j], win[2 + j], win[j]);
    end

    for (genvar k = 0; k < 16; k++) begin : g_shift
        if (k + R < 16) begin : g_keep
            assign win_shift[k] = win[k + R];
        end else begin : g_new
            assign win_shift[k] = nw[k + R - 16];
        end
    end

    for (genvar i = 0; i < R; i++) begin : g_lane
        sha1_state_t st_in, st_out;
        logic [31:0] a_n, b_n, c_n, d_n, e_n;
        if (i == 0) begin : g_first
            assign st_in = vars;
        end else begin : g_chain
            assign st_in = g_lane[i - 1].st_out;
        end
        sha1_round u_round (
            .t     (t + 7'(i)),
            .a     (st_in.a),
            .b     (st_in.b),
            .c     (st_in.c),
            .d     (st_in.d),
            .e     (st_in.e),
            .w     (win[i]),
            .a_nxt (a_n),
            .b_nxt (b_n),
            .c_nxt (c_n),
            .d_nxt (d_n),
            .e_nxt (e_n)
        );
        assign st_out = {a_n, b_n, c_n, d_n, e_n};
    end

    assign vars_nxt = g_lane[R - 1].st_out;
    assign digest   = {base.a + vars.a, base.b + vars.b, base.c + vars.c,
                       base.d + vars.d, base.e + vars.e};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t         <= '0;
            vars      <= '0;
            base      <= '0;
            chain     <= H_INIT;
            d_out     <= '0;
            out_valid <= 1'b0;
            for (int k = 0; k < 16; k++) win[k] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < 16; k++) win[k] <= d_in[511 - 32 * k -: 32];
                        vars <= in_first ? H_INIT : chain;
                        base <= in_first ? H_INIT : chain;
                        t    <= '0;
                    end
                end
                S_RUN: begin
                    vars <= vars_nxt;
                    win  <= win_shift;
                    t    <= t + 7'(R);
                end
                S_FIN: begin
                    chain     <= digest;
                    d_out     <= digest;
                    out_valid <= 1'b1;
                end
                S_DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_core_iter.sv
// Directed bench for sha1_core_iter at R=1, 2 and 4: known digests, latency,
// chaining, backpressure and mid-run reset.
module tb_sha1_core_iter;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_2A    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696A, 32'h68696A6B,
                                          32'h696A6B6C, 32'h6A6B6C6D, 32'h6B6C6D6E, 32'h6C6D6E6F,
                                          32'h6D6E6F70, 32'h6E6F7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_2B    = {480'h0, 32'h000001C0};

    localparam logic [159:0] DIG_ABC   = 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;
    localparam logic [159:0] DIG_EMPTY = 160'hDA39A3EE_5E6B4B0D_3255BFEF_95601890_AFD80709;
    localparam logic [159:0] DIG_2BLK  = 160'h84983E44_1C3BD26E_BAAE4AA1_F95129E5_E54670F1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         in_first  [3];
    logic [511:0] d_in      [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [159:0] d_out     [3];
    logic         busy      [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int RPC = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
        sha1_core_iter #(.ROUNDS_PER_CYCLE(RPC)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .in_first  (in_first[gi]),
            .d_in      (d_in[gi]),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready[gi]),
            .d_out     (d_out[gi]),
            .busy      (busy[gi])
        );
    end

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int idx);
        case (idx)
            0:       return 81;
            1:       return 41;
            default: return 21;
        endcase
    endfunction

    // Present a block and return #1 after the accepting edge; inputs are then scrambled.
    task automatic offer(input int idx, input logic [511:0] blk, input logic first);
        @(negedge clk);
        d_in[idx]     = blk;
        in_first[idx] = first;
        in_valid[idx] = 1'b1;
        for (int i = 0; i < 300 && !in_ready[idx]; i++) @(negedge clk);
        check_eq($sformatf("in_ready_offer_r%0d", idx), 160'(in_ready[idx]), 160'(1));
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
        in_first[idx] = ~first;
        d_in[idx]     = '1;
    endtask

    task automatic wait_out(input int idx, input string tag);
        int cnt;
        cnt = 0;
        do begin
            @(posedge clk);
            cnt++;
            #1;
        end while (!out_valid[idx] && cnt < 300);
        check_eq($sformatf("%s_lat_r%0d", tag, idx), 160'(cnt), 160'(lat_of(idx)));
    endtask

    task automatic take(input int idx, input logic [159:0] exp, input bit do_chk, input string tag);
        @(negedge clk);
        check_eq($sformatf("%s_vld_r%0d", tag, idx), 160'(out_valid[idx]), 160'(1));
        if (do_chk) check_eq($sformatf("%s_dig_r%0d", tag, idx), d_out[idx], exp);
        out_ready[idx] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[idx] = 1'b0;
        check_eq($sformatf("%s_vld_off_r%0d", tag, idx), 160'(out_valid[idx]), 160'(0));
        check_eq($sformatf("%s_rdy_back_r%0d", tag, idx), 160'(in_ready[idx]), 160'(1));
        if (do_chk) check_eq($sformatf("%s_hold_r%0d", tag, idx), d_out[idx], exp);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            in_first[i]  = 1'b0;
            d_in[i]      = '0;
            out_ready[i] = 1'b0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rst_out_valid_r%0d", i), 160'(out_valid[i]), 160'(0));
            check_eq($sformatf("rst_in_ready_r%0d", i), 160'(in_ready[i]), 160'(1));
            check_eq($sformatf("rst_busy_r%0d", i), 160'(busy[i]), 160'(0));
            check_eq($sformatf("rst_d_out_r%0d", i), d_out[i], 160'(0));
        end
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            offer(i, BLK_ABC, 1'b1);
            wait_out(i, "abc");
            take(i, DIG_ABC, 1'b1, "abc");
            offer(i, BLK_2A, 1'b1);
            wait_out(i, "blk2a");
            take(i, '0, 1'b0, "blk2a");
            offer(i, BLK_2B, 1'b0);
            wait_out(i, "blk2b");
            take(i, DIG_2BLK, 1'b1, "blk2b");
            offer(i, BLK_ABC, 1'b1);
            wait_out(i, "abc2");
            take(i, DIG_ABC, 1'b1, "abc2");
        end

        offer(0, BLK_EMPTY, 1'b1);
        wait_out(0, "empty");
        take(0, DIG_EMPTY, 1'b1, "empty");

        // Backpressure: digest held 10 cycles while another block is offered.
        offer(0, BLK_ABC, 1'b1);
        wait_out(0, "bp");
        d_in[0]     = BLK_EMPTY;
        in_first[0] = 1'b1;
        in_valid[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq($sformatf("bp_vld_%0d", k), 160'(out_valid[0]), 160'(1));
            check_eq($sformatf("bp_dig_%0d", k), d_out[0], DIG_ABC);
            check_eq($sformatf("bp_rdy_%0d", k), 160'(in_ready[0]), 160'(0));
        end
        @(negedge clk);
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        check_eq("bp_vld_off", 160'(out_valid[0]), 160'(0));
        check_eq("bp_rdy_idle", 160'(in_ready[0]), 160'(1));
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        check_eq("bp_accept_busy", 160'(busy[0]), 160'(1));
        check_eq("bp_accept_rdy", 160'(in_ready[0]), 160'(0));
        wait_out(0, "bp_next");
        take(0, DIG_EMPTY, 1'b1, "bp_next");

        // Reset at t=40, then a continue-block must chain from the H constants.
        offer(0, BLK_ABC, 1'b1);
        repeat (40) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_vld", 160'(out_valid[0]), 160'(0));
        check_eq("mid_rst_rdy", 160'(in_ready[0]), 160'(1));
        check_eq("mid_rst_busy", 160'(busy[0]), 160'(0));
        check_eq("mid_rst_dout", d_out[0], 160'(0));
        @(negedge clk);
        rst_n = 1'b1;
        offer(0, BLK_ABC, 1'b0);
        wait_out(0, "post_rst");
        take(0, DIG_ABC, 1'b1, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
